// File: rtl/dmem_responder_if.sv
// Request/response bus between the CPU MEM stage (master) and the data memory (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with configurable wait states and
// a one-cycle response pulse carrying load data and an error flag.
module dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  logic [31:0] mem [DEPTH];

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              lat_write;
  logic              lat_err;
  logic [ADDR_W-1:0] lat_idx;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_be;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic              accept;
  logic              req_err;
  logic              enter_resp;
  logic              cur_write;
  logic              cur_err;
  logic [ADDR_W-1:0] cur_idx;
  logic [31:0]       cur_wdata;
  logic [3:0]        cur_be;

  assign accept  = (state == S_IDLE) && bus.req_valid;
  assign req_err = (bus.req_addr[1:0] != 2'b00) ||
                   (bus.req_addr[31:ADDR_W+2] != '0);

  // With zero wait states the RESP edge is the accept edge, so the array access
  // must use the live request rather than the not-yet-latched copy.
  assign enter_resp = (accept && (WAIT_STATES == 0)) ||
                      ((state == S_WAIT) && (cnt == 4'd1));

  always_comb begin
    cur_write = lat_write;
    cur_err   = lat_err;
    cur_idx   = lat_idx;
    cur_wdata = lat_wdata;
    cur_be    = lat_be;
    if (state == S_IDLE) begin
      cur_write = bus.req_write;
      cur_err   = req_err;
      cur_idx   = bus.req_addr[ADDR_W+1:2];
      cur_wdata = bus.req_wdata;
      cur_be    = bus.req_be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_err    <= 1'b0;
      lat_idx    <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_write <= bus.req_write;
            lat_err   <= req_err;
            lat_idx   <= bus.req_addr[ADDR_W+1:2];
            lat_wdata <= bus.req_wdata;
            lat_be    <= bus.req_be;
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WS;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_err   <= cur_err;
        resp_rdata <= (!cur_err && !cur_write) ? mem[cur_idx] : '0;
      end
    end
  end

  // Gated by rst_n so a store whose RESP edge coincides with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && !cur_err && cur_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_rdata;
  assign bus.resp_err   = resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a 2-wait-state instance and a 0-wait-state instance.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  always #5 clk = ~clk;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_STATES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  dmem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on the WAIT_STATES=2 instance; accept edge is cycle 0, response in cycle 3.
  task automatic xact_a(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata,
                        input logic exp_err, input string tag);
    bus_a.req_valid = 1'b1;
    bus_a.req_write = wr;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
    bus_a.req_be    = be;
    check($sformatf("%s ready_c0", tag), {31'd0, bus_a.req_ready}, 32'd1);
    tick();
    bus_a.req_valid = 1'b0;
    bus_a.req_write = ~wr;
    bus_a.req_addr  = 32'h0000_0014;
    bus_a.req_wdata = $urandom;
    bus_a.req_be    = 4'hF;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("%s busy_c%0d", tag, c), {31'd0, bus_a.busy}, 32'd1);
      check($sformatf("%s ready_c%0d", tag, c), {31'd0, bus_a.req_ready}, 32'd0);
      check($sformatf("%s rv_c%0d", tag, c), {31'd0, bus_a.resp_valid}, (c == 3) ? 32'd1 : 32'd0);
      if (c == 3) begin
        check($sformatf("%s rdata", tag), bus_a.resp_rdata, exp_rdata);
        check($sformatf("%s err", tag), {31'd0, bus_a.resp_err}, {31'd0, exp_err});
      end
      tick();
    end
    check($sformatf("%s rv_c4", tag), {31'd0, bus_a.resp_valid}, 32'd0);
    check($sformatf("%s busy_c4", tag), {31'd0, bus_a.busy}, 32'd0);
    check($sformatf("%s rdata_c4", tag), bus_a.resp_rdata, 32'd0);
  endtask

  initial begin
    logic [9:0] acc;
    logic [9:0] rv;

    bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_addr = '0;
    bus_a.req_wdata = '0;   bus_a.req_be = '0;
    bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_addr = '0;
    bus_b.req_wdata = '0;   bus_b.req_be = '0;

    #1;
    check("rst resp_valid", {31'd0, bus_a.resp_valid}, 32'd0);
    check("rst resp_rdata", bus_a.resp_rdata, 32'd0);
    check("rst resp_err", {31'd0, bus_a.resp_err}, 32'd0);
    check("rst busy", {31'd0, bus_a.busy}, 32'd0);
    check("rst req_ready", {31'd0, bus_a.req_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Stores, partial byte enables, empty byte enables and read-after-write
    xact_a(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "st_full");
    xact_a(1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, "ld_full");
    xact_a(1'b1, 32'h0000_0010, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0, "st_be1");
    xact_a(1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0, "ld_be1");
    xact_a(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0000, 32'h0, 1'b0, "st_be0");
    xact_a(1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0, "ld_be0");

    // Misaligned store must not modify memory; out-of-range load errors
    xact_a(1'b1, 32'h0000_0013, 32'h1234_5678, 4'hF, 32'h0, 1'b1, "st_misal");
    xact_a(1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0, "ld_after_misal");
    xact_a(1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0, 1'b1, "ld_oor");

    // Back-to-back: req_valid held, accepts expected at edges 0 and 4, responses in cycles 3 and 7
    acc = '0;
    rv  = '0;
    bus_a.req_valid = 1'b1;
    bus_a.req_write = 1'b0;
    bus_a.req_addr  = 32'h0000_0010;
    for (int k = 0; k <= 8; k++) begin
      acc[k] = bus_a.req_valid & bus_a.req_ready;
      tick();
      if (k == 4) bus_a.req_valid = 1'b0;
      rv[k+1] = bus_a.resp_valid;
      if (bus_a.resp_valid)
        check($sformatf("b2b rdata_c%0d", k + 1), bus_a.resp_rdata, 32'hDEAD_BEAA);
    end
    check("b2b accepts", {22'd0, acc}, 32'b00_0001_0001);
    check("b2b responses", {22'd0, rv}, 32'b00_1000_1000);

    // Reset in the last WAIT cycle of a store aborts it without committing
    xact_a(1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0, 1'b0, "st_prior");
    bus_a.req_valid = 1'b1;
    bus_a.req_write = 1'b1;
    bus_a.req_addr  = 32'h0000_0020;
    bus_a.req_wdata = 32'hCAFE_F00D;
    bus_a.req_be    = 4'hF;
    tick();
    bus_a.req_valid = 1'b0;
    tick();
    check("abort busy_pre", {31'd0, bus_a.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy_rst", {31'd0, bus_a.busy}, 32'd0);
    check("abort ready_rst", {31'd0, bus_a.req_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("abort rv_%0d", k), {31'd0, bus_a.resp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("abort rv_post", {31'd0, bus_a.resp_valid}, 32'd0);
    xact_a(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h1122_3344, 1'b0, "ld_after_abort");

    // Zero wait states: response in cycle 1, next accept at edge 2
    bus_b.req_valid = 1'b1;
    bus_b.req_write = 1'b1;
    bus_b.req_addr  = 32'h0000_0000;
    bus_b.req_wdata = 32'h55AA_55AA;
    bus_b.req_be    = 4'hF;
    check("ws0 ready_c0", {31'd0, bus_b.req_ready}, 32'd1);
    tick();
    bus_b.req_write = 1'b0;
    bus_b.req_wdata = 32'h0;
    check("ws0 st rv_c1", {31'd0, bus_b.resp_valid}, 32'd1);
    check("ws0 st err_c1", {31'd0, bus_b.resp_err}, 32'd0);
    check("ws0 st rdata_c1", bus_b.resp_rdata, 32'd0);
    check("ws0 ready_c1", {31'd0, bus_b.req_ready}, 32'd0);
    check("ws0 busy_c1", {31'd0, bus_b.busy}, 32'd1);
    tick();
    check("ws0 rv_c2", {31'd0, bus_b.resp_valid}, 32'd0);
    check("ws0 ready_c2", {31'd0, bus_b.req_ready}, 32'd1);
    tick();
    bus_b.req_valid = 1'b0;
    check("ws0 ld rv_c3", {31'd0, bus_b.resp_valid}, 32'd1);
    check("ws0 ld rdata_c3", bus_b.resp_rdata, 32'h55AA_55AA);
    tick();
    check("ws0 rv_c4", {31'd0, bus_b.resp_valid}, 32'd0);
    check("ws0 busy_c4", {31'd0, bus_b.busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
